// File: rtl/vga_timing_pkg.sv
// Shared VGA mode constants and helpers for the raster timing generator.
package vga_timing_pkg;

    localparam int unsigned VGA640_H_ACTIVE = 640;
    localparam int unsigned VGA640_H_FP     = 16;
    localparam int unsigned VGA640_H_SYNC   = 96;
    localparam int unsigned VGA640_H_BP     = 48;
    localparam int unsigned VGA640_V_ACTIVE = 480;
    localparam int unsigned VGA640_V_FP     = 10;
    localparam int unsigned VGA640_V_SYNC   = 2;
    localparam int unsigned VGA640_V_BP     = 33;
    localparam bit          VGA640_H_POL    = 1'b0;
    localparam bit          VGA640_V_POL    = 1'b0;

    localparam int unsigned SVGA800_H_ACTIVE = 800;
    localparam int unsigned SVGA800_H_FP     = 40;
    localparam int unsigned SVGA800_H_SYNC   = 128;
    localparam int unsigned SVGA800_H_BP     = 88;
    localparam int unsigned SVGA800_V_ACTIVE = 600;
    localparam int unsigned SVGA800_V_FP     = 1;
    localparam int unsigned SVGA800_V_SYNC   = 4;
    localparam int unsigned SVGA800_V_BP     = 23;
    localparam bit          SVGA800_H_POL    = 1'b1;
    localparam bit          SVGA800_V_POL    = 1'b1;

    // Smallest counter width able to hold both H_TOTAL-1 and V_TOTAL-1.
    function automatic int unsigned min_cw(input int unsigned h_total,
                                           input int unsigned v_total);
        int unsigned max_val;
        int unsigned w;
        max_val = (h_total > v_total) ? h_total : v_total;
        max_val = (max_val == 0) ? 0 : max_val - 1;
        w = 1;
        while ((max_val >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/vga_axis_cnt.sv
// Generic wrap counter for one raster axis; wrap pulses on the enabled
// cycle where the count returns from TOTAL-1 to 0.
module vga_axis_cnt #(
    parameter int unsigned TOTAL = 800,
    parameter int unsigned CW    = 11
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(TOTAL - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign wrap = en && (cnt_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator: registered coordinates, syncs,
// display enable and line/frame strobes, advanced by a pixel clock-enable.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          H_POL    = 1'b0,
    parameter bit          V_POL    = 1'b0,
    parameter int unsigned CW       = 11,
    parameter int unsigned FCW      = 8
) (
    input  logic           pixel_clk,
    input  logic           rst_n,
    input  logic           ce,
    output logic [CW-1:0]  hcount,
    output logic [CW-1:0]  vcount,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic           blank,
    output logic           line_start,
    output logic           frame_start,
    output logic [FCW-1:0] frame_cnt
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_SYNC_BEG = H_ACTIVE + H_FP;
    localparam int unsigned H_SYNC_END = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned V_SYNC_BEG = V_ACTIVE + V_FP;
    localparam int unsigned V_SYNC_END = V_ACTIVE + V_FP + V_SYNC;

    if (CW < min_cw(H_TOTAL, V_TOTAL)) begin : g_bad_cw
        $error("vga_timing_gen: CW too small for H_TOTAL/V_TOTAL");
    end
    if (H_SYNC == 0 || V_SYNC == 0) begin : g_bad_sync
        $error("vga_timing_gen: sync widths must be non-zero");
    end

    logic [CW-1:0] h_cnt;
    logic [CW-1:0] v_cnt;
    logic          h_wrap;

    vga_axis_cnt #(.TOTAL(H_TOTAL), .CW(CW)) u_h_cnt (
        .clk   (pixel_clk),
        .rst_n (rst_n),
        .en    (ce),
        .cnt   (h_cnt),
        .wrap  (h_wrap)
    );

    vga_axis_cnt #(.TOTAL(V_TOTAL), .CW(CW)) u_v_cnt (
        .clk   (pixel_clk),
        .rst_n (rst_n),
        .en    (ce && h_wrap),
        .cnt   (v_cnt),
        .wrap  ()
    );

    logic [CW-1:0]  hcount_q, hcount_d;
    logic [CW-1:0]  vcount_q, vcount_d;
    logic           hsync_q, hsync_d;
    logic           vsync_q, vsync_d;
    logic           de_q, de_d;
    logic           line_start_q, line_start_d;
    logic           frame_start_q, frame_start_d;
    logic [FCW-1:0] frame_cnt_q, frame_cnt_d;

    logic h_in_sync;
    logic v_in_sync;
    logic at_line_origin;
    logic at_frame_origin;

    // Output stage latches the decode of the pre-increment counter position.
    always_comb begin
        h_in_sync       = (32'(h_cnt) >= H_SYNC_BEG) && (32'(h_cnt) < H_SYNC_END);
        v_in_sync       = (32'(v_cnt) >= V_SYNC_BEG) && (32'(v_cnt) < V_SYNC_END);
        at_line_origin  = (h_cnt == '0);
        at_frame_origin = at_line_origin && (v_cnt == '0);

        hcount_d      = hcount_q;
        vcount_d      = vcount_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        de_d          = de_q;
        frame_cnt_d   = frame_cnt_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;

        if (ce) begin
            hcount_d      = h_cnt;
            vcount_d      = v_cnt;
            hsync_d       = h_in_sync ? H_POL : ~H_POL;
            vsync_d       = v_in_sync ? V_POL : ~V_POL;
            de_d          = (32'(h_cnt) < H_ACTIVE) && (32'(v_cnt) < V_ACTIVE);
            line_start_d  = at_line_origin;
            frame_start_d = at_frame_origin;
            if (at_frame_origin) begin
                frame_cnt_d = frame_cnt_q + FCW'(1);
            end
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!rst_n) begin
            hcount_q      <= '0;
            vcount_q      <= '0;
            hsync_q       <= ~H_POL;
            vsync_q       <= ~V_POL;
            de_q          <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            hcount_q      <= hcount_d;
            vcount_q      <= vcount_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign blank       = ~de_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three modes checked every cycle against a
// pixel-index arithmetic model, plus literal timing pins.
module tb_vga_timing_gen;

    typedef struct packed {
        int ha; int hf; int hs; int hb;
        int va; int vf; int vs; int vb;
        bit hp; bit vp; int fcw;
    } mode_t;

    typedef struct packed {
        int hc; int vc; int hs; int vs; int de; int bl; int ls; int fs; int fc;
    } exp_t;

    localparam mode_t MODE_A = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 8};
    localparam mode_t MODE_B = '{800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1, 8};
    localparam mode_t MODE_C = '{10, 2, 3, 2, 6, 1, 2, 2, 1'b1, 1'b0, 2};

    logic pixel_clk = 1'b0;
    logic rst_n;
    logic ce_a, ce_b, ce_c;

    logic [10:0] hcount_a, vcount_a, hcount_b, vcount_b;
    logic [4:0]  hcount_c, vcount_c;
    logic hsync_a, vsync_a, de_a, blank_a, line_start_a, frame_start_a;
    logic hsync_b, vsync_b, de_b, blank_b, line_start_b, frame_start_b;
    logic hsync_c, vsync_c, de_c, blank_c, line_start_c, frame_start_c;
    logic [7:0] frame_cnt_a, frame_cnt_b;
    logic [1:0] frame_cnt_c;

    int tests = 0;
    int fails = 0;

    always #5 pixel_clk = ~pixel_clk;

    vga_timing_gen dut_a (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .ce(ce_a),
        .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
        .de(de_a), .blank(blank_a), .line_start(line_start_a),
        .frame_start(frame_start_a), .frame_cnt(frame_cnt_a)
    );

    vga_timing_gen #(
        .H_ACTIVE(800), .H_FP(40), .H_SYNC(128), .H_BP(88),
        .V_ACTIVE(600), .V_FP(1), .V_SYNC(4), .V_BP(23),
        .H_POL(1'b1), .V_POL(1'b1), .CW(11), .FCW(8)
    ) dut_b (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .ce(ce_b),
        .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
        .de(de_b), .blank(blank_b), .line_start(line_start_b),
        .frame_start(frame_start_b), .frame_cnt(frame_cnt_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(10), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b0), .CW(5), .FCW(2)
    ) dut_c (
        .pixel_clk(pixel_clk), .rst_n(rst_n), .ce(ce_c),
        .hcount(hcount_c), .vcount(vcount_c), .hsync(hsync_c), .vsync(vsync_c),
        .de(de_c), .blank(blank_c), .line_start(line_start_c),
        .frame_start(frame_start_c), .frame_cnt(frame_cnt_c)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // n = enabled edges since reset; the output shows pixel index n-1 of
    // an endless raster scan, so everything follows from div/mod.
    function automatic exp_t model(input longint n, input bit last_ce, input mode_t m);
        exp_t e;
        longint ht, vt, p, x, y, fr;
        ht = m.ha + m.hf + m.hs + m.hb;
        vt = m.va + m.vf + m.vs + m.vb;
        if (n == 0) begin
            e = '{0, 0, int'(!m.hp), int'(!m.vp), 0, 1, 0, 0, 0};
        end else begin
            p  = n - 1;
            x  = p % ht;
            y  = (p / ht) % vt;
            fr = p / (ht * vt);
            e.hc = int'(x);
            e.vc = int'(y);
            e.hs = (x >= m.ha + m.hf && x < m.ha + m.hf + m.hs) ? int'(m.hp) : int'(!m.hp);
            e.vs = (y >= m.va + m.vf && y < m.va + m.vf + m.vs) ? int'(m.vp) : int'(!m.vp);
            e.de = (x < m.ha && y < m.va) ? 1 : 0;
            e.bl = 1 - e.de;
            e.ls = (last_ce && x == 0) ? 1 : 0;
            e.fs = (last_ce && x == 0 && y == 0) ? 1 : 0;
            e.fc = int'((fr + 1) % (64'd1 << m.fcw));
        end
        return e;
    endfunction

    longint n_a = 0, n_b = 0, n_c = 0;
    bit lc_a = 0, lc_b = 0, lc_c = 0;

    always @(posedge pixel_clk) begin
        if (!rst_n) begin
            n_a = 0; n_b = 0; n_c = 0;
            lc_a = 0; lc_b = 0; lc_c = 0;
        end else begin
            lc_a = ce_a; lc_b = ce_b; lc_c = ce_c;
            if (ce_a) n_a++;
            if (ce_b) n_b++;
            if (ce_c) n_c++;
        end
    end

    task automatic cmp_dut(input string p, input exp_t e,
                           input int hc, input int vc, input int hs, input int vs,
                           input int de, input int bl, input int ls, input int fs,
                           input int fc);
        chk({p, ".hcount"}, hc, e.hc);
        chk({p, ".vcount"}, vc, e.vc);
        chk({p, ".hsync"}, hs, e.hs);
        chk({p, ".vsync"}, vs, e.vs);
        chk({p, ".de"}, de, e.de);
        chk({p, ".blank"}, bl, e.bl);
        chk({p, ".line_start"}, ls, e.ls);
        chk({p, ".frame_start"}, fs, e.fs);
        chk({p, ".frame_cnt"}, fc, e.fc);
    endtask

    always @(negedge pixel_clk) begin : compare
        cmp_dut("a", model(n_a, lc_a, MODE_A), int'(hcount_a), int'(vcount_a),
                int'(hsync_a), int'(vsync_a), int'(de_a), int'(blank_a),
                int'(line_start_a), int'(frame_start_a), int'(frame_cnt_a));
        cmp_dut("b", model(n_b, lc_b, MODE_B), int'(hcount_b), int'(vcount_b),
                int'(hsync_b), int'(vsync_b), int'(de_b), int'(blank_b),
                int'(line_start_b), int'(frame_start_b), int'(frame_cnt_b));
        cmp_dut("c", model(n_c, lc_c, MODE_C), int'(hcount_c), int'(vcount_c),
                int'(hsync_c), int'(vsync_c), int'(de_c), int'(blank_c),
                int'(line_start_c), int'(frame_start_c), int'(frame_cnt_c));
    end

    initial begin : stim
        int de_cnt, hs_cnt, hs_min, hs_max, hsb_cnt, hsb_min, hsb_max;
        int vsc_cnt, blc_cnt, ls_a_last, ls_a_num, ls_b_last, ls_b_num, fs_c_last;
        int prev_fc;
        bit wrapped, found;

        rst_n = 1'b0; ce_a = 1'b1; ce_b = 1'b1; ce_c = 1'b1;
        repeat (5) begin
            @(negedge pixel_clk);
            #1;
        end
        chk("rst.hsync_a", hsync_a, 1);
        chk("rst.vsync_a", vsync_a, 1);
        chk("rst.blank_a", blank_a, 1);
        chk("rst.hsync_b", hsync_b, 0);
        chk("rst.frame_cnt_a", frame_cnt_a, 0);

        rst_n = 1'b1;
        de_cnt = 0; hs_cnt = 0; hs_min = 9999; hs_max = -1;
        hsb_cnt = 0; hsb_min = 9999; hsb_max = -1;
        vsc_cnt = 0; blc_cnt = 0; fs_c_last = -1;
        ls_a_last = -1; ls_a_num = 0; ls_b_last = -1; ls_b_num = 0;
        for (int i = 0; i < 2200; i++) begin
            @(negedge pixel_clk);
            if (i == 0) begin
                chk("first.hcount", hcount_a, 0);
                chk("first.vcount", vcount_a, 0);
                chk("first.de", de_a, 1);
                chk("first.line_start", line_start_a, 1);
                chk("first.frame_start", frame_start_a, 1);
                chk("first.frame_cnt", frame_cnt_a, 1);
            end
            if (i == 799) chk("a.hcount_799", hcount_a, 799);
            if (i == 800) begin
                chk("a.hcount_wrap", hcount_a, 0);
                chk("a.vcount_step", vcount_a, 1);
            end
            if (i < 800) begin
                de_cnt += int'(de_a);
                if (!hsync_a) begin
                    hs_cnt++;
                    if (int'(hcount_a) < hs_min) hs_min = int'(hcount_a);
                    if (int'(hcount_a) > hs_max) hs_max = int'(hcount_a);
                end
            end
            if (i < 1056 && hsync_b) begin
                hsb_cnt++;
                if (int'(hcount_b) < hsb_min) hsb_min = int'(hcount_b);
                if (int'(hcount_b) > hsb_max) hsb_max = int'(hcount_b);
            end
            if (i < 187) begin
                vsc_cnt += int'(!vsync_c);
                blc_cnt += int'(blank_c);
            end
            if (line_start_a) begin
                if (ls_a_last >= 0) chk("a.line_period", i - ls_a_last, 800);
                ls_a_last = i; ls_a_num++;
            end
            if (line_start_b) begin
                if (ls_b_last >= 0) chk("b.line_period", i - ls_b_last, 1056);
                ls_b_last = i; ls_b_num++;
            end
            if (frame_start_c) begin
                if (fs_c_last >= 0) chk("c.frame_period", i - fs_c_last, 187);
                fs_c_last = i;
            end
        end
        chk("a.de_per_line", de_cnt, 640);
        chk("a.hsync_width", hs_cnt, 96);
        chk("a.hsync_first", hs_min, 656);
        chk("a.hsync_last", hs_max, 751);
        chk("a.line_starts", ls_a_num, 3);
        chk("b.hsync_width", hsb_cnt, 128);
        chk("b.hsync_first", hsb_min, 840);
        chk("b.hsync_last", hsb_max, 967);
        chk("b.line_starts", ls_b_num, 3);
        chk("c.vsync_cycles", vsc_cnt, 34);
        chk("c.blank_cycles", blc_cnt, 127);

        for (int i = 0; i < 4000; i++) begin
            @(negedge pixel_clk);
            #1;
            ce_a = (i % 4 == 3); ce_b = ce_a; ce_c = ce_a;
        end

        wrapped = 0;
        prev_fc = int'(frame_cnt_c);
        for (int i = 0; i < 20000; i++) begin
            @(negedge pixel_clk);
            if (frame_start_c && frame_cnt_c == 2'd0 && prev_fc == 3) wrapped = 1;
            prev_fc = int'(frame_cnt_c);
            #1;
            ce_a = ($urandom_range(0, 3) != 0);
            ce_b = ($urandom_range(0, 3) != 0);
            ce_c = ($urandom_range(0, 3) != 0);
        end
        chk("c.frame_cnt_wrap", wrapped, 1);

        ce_a = 1'b1; ce_b = 1'b1; ce_c = 1'b1;
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge pixel_clk);
            if (hcount_a == 11'd300) found = 1;
        end
        chk("a.reach_h300", found, 1);
        #1;
        rst_n = 1'b0; ce_a = 1'b0; ce_c = $urandom_range(0, 1) != 0;
        @(negedge pixel_clk);
        chk("midrst.hcount", hcount_a, 0);
        chk("midrst.vcount", vcount_a, 0);
        chk("midrst.hsync", hsync_a, 1);
        chk("midrst.de", de_a, 0);
        chk("midrst.frame_cnt", frame_cnt_a, 0);
        #1;
        rst_n = 1'b1; ce_a = 1'b1; ce_c = 1'b1;
        @(negedge pixel_clk);
        chk("restart.hcount", hcount_a, 0);
        chk("restart.frame_start", frame_start_a, 1);
        chk("restart.frame_cnt", frame_cnt_a, 1);

        for (int i = 0; i < 500; i++) begin
            @(negedge pixel_clk);
            #1;
            ce_a = ($urandom_range(0, 1) != 0);
            ce_b = ($urandom_range(0, 1) != 0);
            ce_c = ($urandom_range(0, 1) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator, the next generation of the fixed 640x480 controller. It produces mutually aligned, registered pixel coordinates, sync pulses, display-enable/blank, and line/frame strobes. Every timing field and sync polarity is a parameter, and a pixel clock-enable lets it run from a faster system clock. It sits between the pixel clock domain and all pixel-generating logic (sprite, background and score renderers) and drives the VGA connector pins.

## Interface
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch, in pixels
- H_SYNC, 96: hsync width, in pixels
- H_BP, 48: horizontal back porch, in pixels
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch, in lines
- V_SYNC, 2: vsync width, in lines
- V_BP, 33: vertical back porch, in lines
- H_POL, 0: hsync active level (0 = active-low)
- V_POL, 0: vsync active level
- CW, 11: coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FCW, 8: frame counter width
- pixel_clk  in  1  the single clock for the block
- rst_n  in  1  reset, synchronous, active-low
- ce  in  1  pixel enable; tie high when pixel_clk is the true pixel rate
- hcount  out  CW  horizontal position of the current output pixel
- vcount  out  CW  vertical position of the current output pixel
- hsync  out  1  horizontal sync, polarity set by H_POL
- vsync  out  1  vertical sync, polarity set by V_POL
- de  out  1  display enable: high inside the active area
- blank  out  1  equals ~de
- line_start  out  1  one-cycle strobe when the output pixel has hcount==0
- frame_start  out  1  one-cycle strobe when the output pixel is at (0,0)
- frame_cnt  out  FCW  number of frames started since reset, wrapping

## Operation
- Derived constants:
  - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 800)
  - V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 525)
- Internal counters h, v (CW bits).
- On each ce=1 cycle:
  - h increments; at h==H_TOTAL-1 it wraps to 0 and v advances.
  - v wraps to 0 after V_TOTAL-1.
  - No value H_TOTAL or V_TOTAL is ever held.
- Decode of the counter position:
  - active = (h < H_ACTIVE) && (v < V_ACTIVE)
  - hsync is asserted for H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC (default 656..751)
  - vsync is asserted for V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC (default 490..491)
  - Deasserted level = ~POL.
- vsync is a function of v only, so it changes with the pixel where h wraps to 0.
- frame_cnt increments, modulo 2^FCW, in the same cycle frame_start is asserted. The reset frame counts: the first frame_start after reset sets frame_cnt=1.
- ce=0 behaviour:
  - h, v and all level outputs (hcount, vcount, hsync, vsync, de, blank, frame_cnt) hold their values.
  - line_start and frame_start are 0.
- Reset (rst_n=0 at a pixel_clk edge), regardless of ce:
  - h=0, v=0, hcount=0, vcount=0
  - hsync=~H_POL, vsync=~V_POL
  - de=0, blank=1
  - line_start=0, frame_start=0, frame_cnt=0
- Reset mid-frame aborts the frame immediately. There is no partial-line completion.

## Timing
- Every output is a flop. There are no combinational paths from inputs to outputs.
- Output pipeline:
  - On a ce=1 edge, outputs load the decode of the current (h,v), and the counters advance in the same edge.
  - All outputs therefore describe one position and are mutually aligned.
- First ce=1 edge after reset release:
  - Outputs show (0,0) with de=1 (for non-zero active sizes), line_start=1, frame_start=1 and frame_cnt=1.
  - Counters move to (1,0).
- Latency from a ce=1 edge to the outputs for that pixel is 1 pixel_clk cycle.
- Line period is H_TOTAL ce pulses; frame period is H_TOTAL·V_TOTAL ce pulses (420000 by default).
- rst_n and ce arriving together: rst_n wins.

## Structure
- Shared package vga_timing_pkg:
  - Default mode constants for 640x480@60: 640/16/96/48, 480/10/2/33, negative polarities.
  - Default mode constants for 800x600@60: 800/40/128/88, 600/1/4/23, positive polarities.
  - A function computing the minimum CW from the totals.
- One sub-module, vga_axis_cnt, instantiated twice:
  - Contents: a generic wrap counter (TOTAL, CW) with en input, wrap output and synchronous active-low reset.
  - Horizontal instance: en=ce.
  - Vertical instance: en = ce && h_wrap.
- Parameter sanity: an elaboration-time check rejects CW too small and any zero sync width.

## Test plan
- Reset: hold rst_n=0 for 5 cycles with ce=1. Expect all outputs at their reset values (default polarities: hsync=1, vsync=1, blank=1). On the first edge after release expect hcount=0, vcount=0, de=1, frame_start=1, frame_cnt=1.
- One line, defaults, ce=1:
  - de is high for exactly 640 cycles, and hcount runs 0..799 then returns to 0.
  - hsync is low exactly while hcount = 656..751.
  - line_start occurs every 800 cycles.
- Full frame:
  - vsync is low exactly while vcount = 490..491, i.e. 1600 cycles.
  - blank=1 throughout vcount 480..524.
  - frame_start pulses are 420000 cycles apart, and frame_cnt increments by 1 at each.
- ce=1 on every 4th cycle: every output timing stretches ×4; levels hold between pulses; each strobe is exactly 1 pixel_clk wide.
- Positive-polarity 800x600 mode (H_POL=1, V_POL=1, CW=11):
  - Line period is 1056; frame period is 1056·628.
  - hsync is high for hcount 840..967.
  - vsync is high for vcount 601..604.
- Reset at hcount=300, vcount=200: the next edge gives reset values, and counting restarts from (0,0) with frame_start. Separately, with FCW=2, frame_cnt wraps 3→0.
